// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared command type, address/field layout and FSM states for sprite_update_master
package sprite_pkg;

    typedef struct packed {
        logic        is_bg;
        logic [6:0]  idx;
        logic [11:0] x;
        logic [11:0] y;
        logic [4:0]  sprite;
        logic        active;
        logic [23:0] bg;
    } obj_cmd_t;

    localparam int CMD_W         = $bits(obj_cmd_t);
    localparam int BG_ADDR       = 0;
    localparam int OBJ_ADDR_BASE = 1;
    localparam int X_LSB         = 20;
    localparam int Y_LSB         = 8;
    localparam int SPR_LSB       = 3;
    localparam int ACT_BIT       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Slave write-data word for one command; unused low bits of an object word stay zero.
    function automatic logic [31:0] encode_data(obj_cmd_t c);
        logic [31:0] d;
        d = '0;
        if (c.is_bg) begin
            d = {8'h00, c.bg};
        end else begin
            d[X_LSB +: 12]  = c.x;
            d[Y_LSB +: 12]  = c.y;
            d[SPR_LSB +: 5] = c.sprite;
            d[ACT_BIT]      = c.active;
        end
        return d;
    endfunction

endpackage

// File: rtl/sprite_update_master_fifo.sv
// rtl/sprite_update_master_fifo.sv - synchronous FIFO with head and head+1 read ports
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [WIDTH-1:0]         rdata_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full       = (level == (AW+1)'(DEPTH));
    assign empty      = (level == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rdata      = mem[rd_ptr];
    // Lets the master load the following entry in the same edge that retires the head.
    assign rdata_next = mem[rd_ptr + AW'(1)];

    // Pointer and occupancy tracking; a push and pop together leave the level unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + (AW+1)'(1);
            else if (do_pop && !do_push) level <= level - (AW+1)'(1);
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sprite_update_master.sv
// rtl/sprite_update_master.sv - buffers sprite/background updates and writes them to the slave during vblank
module sprite_update_master
    import sprite_pkg::*;
#(
    parameter int MAX_OBJECTS = 100,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_W      = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_is_bg,
    input  logic [6:0]                    cmd_idx,
    input  logic [11:0]                   cmd_x,
    input  logic [11:0]                   cmd_y,
    input  logic [4:0]                    cmd_sprite,
    input  logic                          cmd_active,
    input  logic [23:0]                   cmd_bg,
    input  logic                          vblank,
    output logic [ADDR_W-1:0]             avm_address,
    output logic [31:0]                   avm_writedata,
    output logic                          avm_write,
    output logic                          avm_chipselect,
    input  logic                          avm_waitrequest,
    output logic                          frame_done,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] MAX_OBJ_L = 8'(MAX_OBJECTS);

    state_t     state;
    state_t     next_state;
    logic       vblank_q;
    logic       vblank_rise;
    logic [LW-1:0] budget;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push_req;
    logic       idx_ok;
    logic       store;
    logic       drop;
    logic       accept;
    obj_cmd_t   wr_cmd;
    obj_cmd_t   head;
    obj_cmd_t   head_next;

    assign cmd_ready   = !fifo_full;
    assign push_req    = cmd_valid && cmd_ready;
    assign idx_ok      = ({1'b0, cmd_idx} < MAX_OBJ_L);
    assign store       = push_req && (cmd_is_bg || idx_ok);
    assign drop        = push_req && !cmd_is_bg && !idx_ok;
    assign vblank_rise = vblank && !vblank_q;
    assign accept      = avm_write && !avm_waitrequest;

    assign wr_cmd = '{is_bg: cmd_is_bg, idx: cmd_idx, x: cmd_x, y: cmd_y,
                      sprite: cmd_sprite, active: cmd_active, bg: cmd_bg};

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (store),
        .pop        (accept),
        .wdata      (wr_cmd),
        .rdata      (head),
        .rdata_next (head_next),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    function automatic logic [ADDR_W-1:0] encode_addr(obj_cmd_t c);
        if (c.is_bg) return ADDR_W'(BG_ADDR);
        return ADDR_W'(c.idx) + ADDR_W'(OBJ_ADDR_BASE);
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state: a write in flight always completes before the window may close.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (vblank_rise) next_state = (fifo_level == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (accept && (budget == LW'(1) || !vblank)) next_state = DONE;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered bus outputs; the next entry is loaded on the accepting edge for gapless writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            avm_write      <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            frame_done     <= 1'b0;
        end else begin
            avm_write      <= (next_state == ISSUE);
            avm_chipselect <= (next_state == ISSUE);
            frame_done     <= (next_state == DONE);
            if (state == IDLE && next_state == ISSUE) begin
                avm_address   <= encode_addr(head);
                avm_writedata <= encode_data(head);
            end else if (state == ISSUE && accept && next_state == ISSUE) begin
                avm_address   <= encode_addr(head_next);
                avm_writedata <= encode_data(head_next);
            end
        end
    end

    // Frame budget: entries present at the vblank edge, counted down per accepted write.
    always_ff @(posedge clk) begin
        if (reset) begin
            budget <= '0;
        end else if (state == IDLE && vblank_rise) begin
            budget <= fifo_level;
        end else if (state == ISSUE && accept) begin
            budget <= budget - LW'(1);
        end
    end

    // vblank edge history and saturating reject counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            vblank_q   <= 1'b0;
            drop_count <= '0;
        end else begin
            vblank_q <= vblank;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    logic unused_ok;
    assign unused_ok = fifo_empty;

endmodule

// File: tb/tb_sprite_update_master.sv
// tb/tb_sprite_update_master.sv - scoreboard bench for sprite_update_master
module tb_sprite_update_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_is_bg;
    logic [6:0]  cmd_idx;
    logic [11:0] cmd_x;
    logic [11:0] cmd_y;
    logic [4:0]  cmd_sprite;
    logic        cmd_active;
    logic [23:0] cmd_bg;
    logic        vblank;
    logic [6:0]  avm_address;
    logic [31:0] avm_writedata;
    logic        avm_write;
    logic        avm_chipselect;
    logic        avm_waitrequest;
    logic        frame_done;
    logic [15:0] drop_count;
    logic [4:0]  fifo_level;

    typedef struct {
        logic [6:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          done_pulses = 0;
    bit          prev_stall = 0;
    logic [6:0]  hold_a;
    logic [31:0] hold_d;

    always #5 clk = ~clk;

    sprite_update_master #(
        .MAX_OBJECTS (100),
        .FIFO_DEPTH  (16),
        .ADDR_W      (7)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_is_bg       (cmd_is_bg),
        .cmd_idx         (cmd_idx),
        .cmd_x           (cmd_x),
        .cmd_y           (cmd_y),
        .cmd_sprite      (cmd_sprite),
        .cmd_active      (cmd_active),
        .cmd_bg          (cmd_bg),
        .vblank          (vblank),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_write       (avm_write),
        .avm_chipselect  (avm_chipselect),
        .avm_waitrequest (avm_waitrequest),
        .frame_done      (frame_done),
        .drop_count      (drop_count),
        .fifo_level      (fifo_level)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: retires one scoreboard entry per accepted write, checks hold during stalls.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                check("hold_write", {31'd0, avm_write}, 32'd1);
                check("hold_addr", {25'd0, avm_address}, {25'd0, hold_a});
                check("hold_data", avm_writedata, hold_d);
            end
            if (avm_write && !avm_waitrequest) begin
                check("chipselect", {31'd0, avm_chipselect}, 32'd1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h/%0h required=none", avm_address, avm_writedata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", {25'd0, avm_address}, {25'd0, e.a});
                    check("wr_data", avm_writedata, e.d);
                end
            end
            if (frame_done) done_pulses++;
            prev_stall = avm_write && avm_waitrequest;
            hold_a     = avm_address;
            hold_d     = avm_writedata;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input bit bg, input int idx, input int x, input int y, input int spr,
                            input bit act, input logic [23:0] bgc,
                            input logic [6:0] ea, input logic [31:0] ed, input bit store);
        exp_t e;
        cmd_valid  = 1'b1;
        cmd_is_bg  = bg;
        cmd_idx    = 7'(idx);
        cmd_x      = 12'(x);
        cmd_y      = 12'(y);
        cmd_sprite = 5'(spr);
        cmd_active = act;
        cmd_bg     = bgc;
        tick();
        cmd_valid  = 1'b0;
        if (store) begin
            e.a = ea;
            e.d = ed;
            sb.push_back(e);
        end
    endtask

    // Raise vblank and count edges until frame_done; optional vblank drop and stall release.
    task automatic run_frame(input string name, input int high_cycles, input int stall_cycles,
                             input int exp_cycles);
        int cyc;
        int pulses0;
        bit seen;
        pulses0 = done_pulses;
        cyc     = 0;
        seen    = 0;
        vblank  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            cyc++;
            if (high_cycles > 0 && cyc == high_cycles) vblank = 1'b0;
            if (stall_cycles > 0 && cyc == stall_cycles) avm_waitrequest = 1'b0;
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_frame_done required=frame_done", name);
        end else begin
            check({name, "_cycles"}, cyc, exp_cycles);
        end
        vblank = 1'b0;
        tick();
        check({name, "_done_width"}, {31'd0, frame_done}, 32'd0);
        tick();
        check({name, "_done_pulses"}, done_pulses - pulses0, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_is_bg = 1'b0; cmd_idx = '0; cmd_x = '0; cmd_y = '0;
        cmd_sprite = '0; cmd_active = 1'b0; cmd_bg = '0;
        vblank = 1'b0; avm_waitrequest = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_write", {31'd0, avm_write}, 32'd0);
        check("rst_cs", {31'd0, avm_chipselect}, 32'd0);
        check("rst_addr", {25'd0, avm_address}, 32'd0);
        check("rst_data", avm_writedata, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_drop", {16'd0, drop_count}, 32'd0);
        check("rst_level", {27'd0, fifo_level}, 32'd0);
        tick();

        // Three objects, back-to-back writes starting one cycle after the edge.
        push_cmd(0, 0, 1, 2, 0, 1, 24'h0, 7'd1, 32'h00100204, 1);
        push_cmd(0, 5, 100, 50, 3, 1, 24'h0, 7'd6, 32'h0640321C, 1);
        push_cmd(0, 99, 12'hFFF, 12'hFFF, 31, 0, 24'h0, 7'd100, 32'hFFFFFFF8, 1);
        check("t1_level", {27'd0, fifo_level}, 32'd3);
        run_frame("t1", 0, 0, 4);
        check("t1_level_after", {27'd0, fifo_level}, 32'd0);

        // Background ignores the index field.
        push_cmd(1, 55, 7, 7, 7, 1, 24'h123456, 7'd0, 32'h00123456, 1);
        run_frame("t2", 0, 0, 2);

        // Out-of-range object indices are counted and never written.
        push_cmd(0, 100, 1, 1, 1, 1, 24'h0, 7'd0, 32'd0, 0);
        push_cmd(0, 127, 1, 1, 1, 1, 24'h0, 7'd0, 32'd0, 0);
        check("t3_drop", {16'd0, drop_count}, 32'd2);
        check("t3_level", {27'd0, fifo_level}, 32'd0);
        run_frame("t3", 0, 0, 1);

        // Fill to full, refuse a 17th, then drain with a 3-cycle stall on the first write.
        for (int i = 0; i < 16; i++)
            push_cmd(0, i, 3 * i, 200 + i, i, 1, 24'h0, 7'(i + 1),
                     {12'(3 * i), 12'(200 + i), 5'(i), 1'b1, 2'b00}, 1);
        check("t4_full_ready", {31'd0, cmd_ready}, 32'd0);
        check("t4_full_level", {27'd0, fifo_level}, 32'd16);
        push_cmd(0, 42, 9, 9, 9, 1, 24'h0, 7'd0, 32'd0, 0);
        check("t4_17th_level", {27'd0, fifo_level}, 32'd16);
        avm_waitrequest = 1'b1;
        run_frame("t4", 0, 4, 20);
        check("t4_level_after", {27'd0, fifo_level}, 32'd0);
        check("t4_ready_after", {31'd0, cmd_ready}, 32'd1);

        // Short vblank window: 4 writes, remainder waits for the next frame.
        for (int i = 0; i < 10; i++)
            push_cmd(0, 10 + i, i, 2 * i, i, i[0], 24'h0, 7'(11 + i),
                     {12'(i), 12'(2 * i), 5'(i), i[0], 2'b00}, 1);
        run_frame("t5a", 4, 0, 5);
        check("t5a_level", {27'd0, fifo_level}, 32'd6);
        check("t5a_pending", sb.size(), 32'd6);
        run_frame("t5b", 0, 0, 7);
        check("t5b_level", {27'd0, fifo_level}, 32'd0);

        // Reset while a write is stalled on the bus.
        push_cmd(0, 1, 1, 1, 1, 1, 24'h0, 7'd2, 32'h0010010C, 1);
        push_cmd(0, 2, 2, 2, 2, 1, 24'h0, 7'd3, 32'h00200214, 1);
        avm_waitrequest = 1'b1;
        vblank = 1'b1;
        tick();
        check("t6_write_up", {31'd0, avm_write}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("t6_write_dn", {31'd0, avm_write}, 32'd0);
        check("t6_level", {27'd0, fifo_level}, 32'd0);
        check("t6_drop", {16'd0, drop_count}, 32'd0);
        avm_waitrequest = 1'b0;
        vblank = 1'b0;
        tick();
        run_frame("t6", 0, 0, 1);

        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
